pipelined_memory: RTL and testbench
===================================

PIPELINED_MEMORY -- requirements
Module: pipelined_memory

Interface
REQ-001 SHALL have parameter WORD, default 16: data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter BYTES, default 65536: memory size in bytes, a multiple of WORD/8.
REQ-003 SHALL have parameter READ_PORTS, default 2: number of independent read ports.
REQ-004 SHALL have parameter READ_LATENCY, default 1: cycles from read acceptance to rd_valid, legal range 1..4.
REQ-005 SHALL have parameter INIT_CLEAR, default 1: 1 = hardware zero-fill after reset, 0 = no fill.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port rd_req[READ_PORTS], input, 1 bit each: read request per port.
REQ-009 SHALL have port rd_addr[READ_PORTS], input, $clog2(BYTES) bits each: byte address per port.
REQ-010 SHALL have port wr_be, input, WORD/8 bits: byte write enables; bit n writes bits 8n+7..8n.
REQ-011 SHALL have port wr_addr, input, $clog2(BYTES) bits: write byte address.
REQ-012 SHALL have port wr_data, input, WORD bits: write data.
REQ-013 SHALL have port ready, output, 1 bit: high when read and write requests are accepted.
REQ-014 SHALL have port rd_valid[READ_PORTS], output, 1 bit each: one-cycle pulse marking valid rd_data.
REQ-015 SHALL have port rd_data[READ_PORTS], output, WORD bits each: read data, held between pulses.

Function
REQ-016 SHALL form the word index from an address by dropping its low $clog2(WORD/8) bits; those low bits SHALL be ignored.
REQ-017 SHALL implement states INIT and RUN; ready SHALL be registered and high only in RUN.
REQ-018 SHALL, with INIT_CLEAR=1, enter INIT after reset and write zero to word k on the k-th cycle, k = 0..BYTES/(WORD/8)-1; it SHALL enter RUN on the edge after the last word is written.
REQ-019 SHALL, with INIT_CLEAR=0, enter RUN on the first edge after reset release; memory contents are then undefined.
REQ-020 SHALL ignore rd_req and wr_be while ready is low.
REQ-021 SHALL accept a read on a port when ready and rd_req are both high at a rising edge.
REQ-022 SHALL pulse rd_valid for exactly one cycle, READ_LATENCY edges after acceptance.
REQ-023 SHALL sustain one accepted read per port per cycle.
REQ-024 SHALL update rd_data together with each rd_valid pulse and hold it otherwise.
REQ-025 SHALL, at an edge where ready is high, write every byte whose wr_be bit is set and leave all other bytes unchanged.
REQ-026 SHALL return, for a read accepted in the same cycle as a write to the same word, the new bytes where wr_be is set and the old bytes elsewhere (write-first).
REQ-027 SHALL capture read data at acceptance, so later writes do not alter reads already in flight.
REQ-028 SHALL allow any number of ports to read the same word in the same cycle, each returning identical data.
REQ-029 SHALL raise an elaboration error if READ_LATENCY is outside 1..4, WORD%8 != 0, or BYTES%(WORD/8) != 0.

Reset
REQ-030 SHALL, while rst_n is low, immediately force ready=0, all rd_valid=0, all rd_data=0, the state to INIT (RUN if INIT_CLEAR=0) and the init counter to 0.
REQ-031 SHALL discard all in-flight reads on reset; none SHALL produce rd_valid afterwards.
REQ-032 SHALL restart the zero-fill from word 0 if reset is asserted during INIT.

Structure
REQ-033 SHALL take from shared package mem_pkg: the state enum (INIT, RUN), constant BYTE=8, and a bytes-per-word helper function.
REQ-034 SHALL build each port's latency delay line (valid bit plus data) in sub-module mem_read_pipe, instanced once per port.

Verification (WORD=16, BYTES=64, READ_PORTS=2, READ_LATENCY=2, INIT_CLEAR=1)
REQ-035 SHALL check zero-fill: release reset -> ready low for 32 cycles, high on cycle 33; a read of 0x3E then returns 0x0000.
REQ-036 SHALL check byte writes: write 0xABCD, be=01 at 0x04, then 0x12FF, be=10 -> port 0 read of 0x05 gives 0x12CD 2 cycles later, with a 1-cycle rd_valid.
REQ-037 SHALL check write-first: word 0x06 holds 0x1111; write 0x2222, be=01 and read 0x06 in the same cycle -> 0x1122.
REQ-038 SHALL check throughput: both ports read different words every cycle for 8 cycles -> 8 consecutive valid pulses per port, all data correct.
REQ-039 SHALL check reset mid-operation: reset with a read in flight at init count 10 -> no rd_valid follows; zero-fill reruns for the full 32 cycles.
REQ-040 SHALL check gating: write 0xFFFF, be=11 at 0x00 while ready is low -> a read of 0x00 after INIT returns 0x0000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the pipelined memory block.
package mem_pkg;

    localparam int BYTE = 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } mem_state_e;

    // Number of bytes packed into one data word.
    function automatic int bytes_per_word(input int word);
        return word / BYTE;
    endfunction

endpackage

// File: rtl/pipelined_memory_if.sv
// Request/response bus of the pipelined memory: per-port reads plus one byte-enabled write.
interface pipelined_memory_if
    import mem_pkg::*;
#(
    parameter int WORD       = 16,
    parameter int BYTES      = 65536,
    parameter int READ_PORTS = 2
);
    localparam int AW = $clog2(BYTES);

    logic [READ_PORTS-1:0]           rd_req;
    logic [READ_PORTS-1:0][AW-1:0]   rd_addr;
    logic [WORD/BYTE-1:0]            wr_be;
    logic [AW-1:0]                   wr_addr;
    logic [WORD-1:0]                 wr_data;
    logic                            ready;
    logic [READ_PORTS-1:0]           rd_valid;
    logic [READ_PORTS-1:0][WORD-1:0] rd_data;

    modport master (
        output rd_req, rd_addr, wr_be, wr_addr, wr_data,
        input  ready, rd_valid, rd_data
    );

    modport slave (
        input  rd_req, rd_addr, wr_be, wr_addr, wr_data,
        output ready, rd_valid, rd_data
    );

endinterface

// File: rtl/mem_read_pipe.sv
// Per-port read latency line: valid shift register plus data stages that only
// advance with a valid bit, so the output data holds between pulses.
module mem_read_pipe #(
    parameter int WORD = 16,
    parameter int LAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    input  logic [WORD-1:0] in_data,
    output logic            out_vld,
    output logic [WORD-1:0] out_data
);

    logic [LAT:1]           vld_pipe;
    logic [LAT:1][WORD-1:0] dat_pipe;

    // Shift valid every cycle; move data only behind a valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= in_vld;
            if (in_vld) dat_pipe[1] <= in_data;
            for (int i = 2; i <= LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[LAT];
    assign out_data = dat_pipe[LAT];

endmodule

// File: rtl/pipelined_memory.sv
// Multi-port read, single byte-enabled write memory with optional zero-fill
// after reset and a fixed read latency per port.
module pipelined_memory
    import mem_pkg::*;
#(
    parameter int WORD         = 16,
    parameter int BYTES        = 65536,
    parameter int READ_PORTS   = 2,
    parameter int READ_LATENCY = 1,
    parameter int INIT_CLEAR   = 1
) (
    input logic               clk,
    input logic               rst_n,
    pipelined_memory_if.slave bus
);

    localparam int BPW   = bytes_per_word(WORD);
    localparam int AW    = $clog2(BYTES);
    localparam int OFF   = $clog2(BPW);
    localparam int WIDX  = AW - OFF;
    localparam int WORDS = BYTES / BPW;
    localparam int CW    = $clog2(WORDS + 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
        $error("pipelined_memory: READ_LATENCY must be 1..4");
    end
    if (WORD % BYTE != 0) begin : g_bad_word
        $error("pipelined_memory: WORD must be a multiple of 8");
    end
    if (BYTES % BPW != 0) begin : g_bad_bytes
        $error("pipelined_memory: BYTES must be a multiple of WORD/8");
    end

    mem_state_e state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          fill_we;
    logic          ready_q;

    logic [WORD-1:0] mem [WORDS];
    logic [WIDX-1:0] widx;

    logic [READ_PORTS-1:0]           acc;
    logic [READ_PORTS-1:0][WORD-1:0] rd_cap;
    logic [READ_PORTS-1:0]           pipe_vld;
    logic [READ_PORTS-1:0][WORD-1:0] pipe_dat;

    // Low address bits select a byte within a word and are dropped.
    assign widx = bus.wr_addr[AW-1:OFF];

    // Fill sequencing: one word per cycle, then a spare edge to enter RUN.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fill_we  = 1'b0;
        case (state)
            INIT: begin
                if (cnt == CW'(WORDS)) begin
                    state_nx = RUN;
                end else begin
                    fill_we = 1'b1;
                    cnt_nx  = cnt + CW'(1);
                end
            end
            RUN: ;
            default: state_nx = INIT;
        endcase
    end

    // State, fill counter and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (INIT_CLEAR != 0) ? INIT : RUN;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            ready_q <= (state_nx == RUN);
        end
    end

    // Storage array has no reset; the fill walk is what clears it.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            mem[cnt[WIDX-1:0]] <= '0;
        end else if (ready_q) begin
            for (int b = 0; b < BPW; b++) begin
                if (bus.wr_be[b]) mem[widx][b*BYTE +: BYTE] <= bus.wr_data[b*BYTE +: BYTE];
            end
        end
    end

    assign acc = bus.rd_req & {READ_PORTS{ready_q}};

    // Read data captured at acceptance, with same-cycle write bytes merged in.
    always_comb begin
        rd_cap = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_cap[p] = mem[bus.rd_addr[p][AW-1:OFF]];
            for (int b = 0; b < BPW; b++) begin
                if (ready_q && bus.wr_be[b] && (widx == bus.rd_addr[p][AW-1:OFF]))
                    rd_cap[p][b*BYTE +: BYTE] = bus.wr_data[b*BYTE +: BYTE];
            end
        end
    end

    mem_read_pipe #(
        .WORD (WORD),
        .LAT  (READ_LATENCY)
    ) u_pipe [READ_PORTS-1:0] (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (acc),
        .in_data  (rd_cap),
        .out_vld  (pipe_vld),
        .out_data (pipe_dat)
    );

    assign bus.ready    = ready_q;
    assign bus.rd_valid = pipe_vld;
    assign bus.rd_data  = pipe_dat;

    if (OFF > 0) begin : g_lo
        logic unused_lo;
        // Byte-offset bits carry no meaning for word access.
        always_comb begin
            unused_lo = ^bus.wr_addr[OFF-1:0];
            for (int p = 0; p < READ_PORTS; p++) unused_lo = unused_lo ^ (^bus.rd_addr[p][OFF-1:0]);
        end
    end

endmodule

// File: tb/tb_pipelined_memory.sv
// Directed bench for pipelined_memory: WORD=16, BYTES=64, 2 ports, latency 2, zero-fill on.
module tb_pipelined_memory;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    pipelined_memory_if #(.WORD(16), .BYTES(64), .READ_PORTS(2)) bus ();

    pipelined_memory #(
        .WORD         (16),
        .BYTES        (64),
        .READ_PORTS   (2),
        .READ_LATENCY (2),
        .INIT_CLEAR   (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.rd_req  = '0;
        bus.wr_be   = '0;
    endtask

    // Count edges until ready rises (bounded), tallying any stray rd_valid.
    task automatic wait_ready(output int n, output int stray);
        n = 0;
        stray = 0;
        do begin
            tick;
            n++;
            if (bus.rd_valid != 2'b00) stray++;
        end while (!bus.ready && n < 41);
    endtask

    task automatic wr(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be   = be;
        tick;
        bus.wr_be   = '0;
    endtask

    task automatic rd(input logic [1:0] m, input logic [5:0] a0, input logic [5:0] a1,
                      input logic [15:0] e0, input logic [15:0] e1);
        bus.rd_req     = m;
        bus.rd_addr[0] = a0;
        bus.rd_addr[1] = a1;
        tick;
        bus.rd_req = '0;
        chk("rd_early", 32'(bus.rd_valid), 32'(2'b00));
        tick;
        chk("rd_vld", 32'(bus.rd_valid), 32'(m));
        if (m[0]) chk("rd_data0", 32'(bus.rd_data[0]), 32'(e0));
        if (m[1]) chk("rd_data1", 32'(bus.rd_data[1]), 32'(e1));
        tick;
        chk("rd_pulse", 32'(bus.rd_valid), 32'(2'b00));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, stray, cnt0, cnt1;

        // Reset with a write and reads held active throughout INIT.
        bus.rd_req     = 2'b11;
        bus.rd_addr[0] = 6'h00;
        bus.rd_addr[1] = 6'h00;
        bus.wr_addr    = 6'h00;
        bus.wr_data    = 16'hFFFF;
        bus.wr_be      = 2'b11;
        #12;
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_vld", 32'(bus.rd_valid), 0);
        chk("rst_data", 32'(bus.rd_data), 0);
        rst_n = 1'b1;
        wait_ready(n, stray);
        idle;
        chk("init_len", n, 33);
        chk("init_stray_vld", stray, 0);

        // Gated write left word 0 clear; fill reached the top word.
        rd(2'b01, 6'h00, 6'h00, 16'h0000, 16'h0000);
        rd(2'b10, 6'h00, 6'h3E, 16'h0000, 16'h0000);

        // Byte-lane writes, odd address read, shared-word read on both ports.
        wr(6'h04, 16'hABCD, 2'b01);
        wr(6'h04, 16'h12FF, 2'b10);
        rd(2'b01, 6'h05, 6'h00, 16'h12CD, 16'h0000);
        rd(2'b11, 6'h04, 6'h05, 16'h12CD, 16'h12CD);

        // Write-first on a same-cycle read of the written word.
        wr(6'h06, 16'h1111, 2'b11);
        bus.wr_addr    = 6'h06;
        bus.wr_data    = 16'h2222;
        bus.wr_be      = 2'b01;
        bus.rd_req     = 2'b01;
        bus.rd_addr[0] = 6'h06;
        tick;
        idle;
        chk("wf_early", 32'(bus.rd_valid), 0);
        tick;
        chk("wf_vld", 32'(bus.rd_valid), 32'(2'b01));
        chk("wf_data", 32'(bus.rd_data[0]), 32'h1122);

        // Write after acceptance does not reach the in-flight read.
        bus.rd_req     = 2'b01;
        bus.rd_addr[0] = 6'h06;
        tick;
        bus.rd_req  = '0;
        bus.wr_addr = 6'h06;
        bus.wr_data = 16'h3333;
        bus.wr_be   = 2'b11;
        tick;
        idle;
        chk("inflight_vld", 32'(bus.rd_valid), 32'(2'b01));
        chk("inflight_data", 32'(bus.rd_data[0]), 32'h1122);
        tick;
        chk("hold_data", 32'(bus.rd_data[0]), 32'h1122);
        rd(2'b01, 6'h06, 6'h00, 16'h3333, 16'h0000);

        // Back-to-back reads on both ports over distinct preloaded words.
        for (int i = 8; i < 24; i++) wr(6'(2 * i), 16'h5A00 | 16'(i), 2'b11);
        cnt0 = 0;
        cnt1 = 0;
        for (int j = 0; j < 10; j++) begin
            bus.rd_req     = (j < 8) ? 2'b11 : 2'b00;
            bus.rd_addr[0] = 6'(2 * (8 + j));
            bus.rd_addr[1] = 6'(2 * (16 + j) + 1);
            tick;
            if (bus.rd_valid[0]) cnt0++;
            if (bus.rd_valid[1]) cnt1++;
            if (j >= 1 && j <= 8) begin
                chk("tp_vld", 32'(bus.rd_valid), 32'(2'b11));
                chk("tp_data0", 32'(bus.rd_data[0]), 32'(16'h5A00 | 16'(8 + j - 1)));
                chk("tp_data1", 32'(bus.rd_data[1]), 32'(16'h5A00 | 16'(16 + j - 1)));
            end else begin
                chk("tp_idle", 32'(bus.rd_valid), 0);
            end
        end
        idle;
        chk("tp_cnt0", cnt0, 8);
        chk("tp_cnt1", cnt1, 8);

        // Reset with a read in flight, then again partway through the fill.
        wr(6'h10, 16'hBEEF, 2'b11);
        bus.rd_req     = 2'b01;
        bus.rd_addr[0] = 6'h10;
        tick;
        idle;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(bus.ready), 0);
        chk("mid_rst_vld", 32'(bus.rd_valid), 0);
        chk("mid_rst_data", 32'(bus.rd_data), 0);
        tick;
        rst_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (bus.rd_valid != 2'b00 || bus.ready) stray++;
        end
        chk("fill10_quiet", stray, 0);
        rst_n = 1'b0;
        #2;
        chk("refill_rst_ready", 32'(bus.ready), 0);
        rst_n = 1'b1;
        wait_ready(n, stray);
        chk("refill_len", n, 33);
        chk("refill_stray_vld", stray, 0);
        rd(2'b11, 6'h10, 6'h3E, 16'h0000, 16'h0000);
        rd(2'b01, 6'h05, 6'h00, 16'h0000, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
